writeback_arbiter: RTL and testbench

Writeback stage sitting directly upstream of the 32×32 `regfile`, which has two read ports and one write port. It accepts register-write requests from two producers, the ALU and the memory unit, each over a valid/ready handshake. It buffers one request per source and serialises them onto the single regfile write port in age order. It also provides bypassed read data so decode sees writes that are still pending.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_slot.sv | 51 +++++
 rtl/writeback_arbiter.sv | 136 +++++++++++++
 tb/tb_writeback_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: widths, source select and the
// hard-wired zero register index.
package wb_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_e;

   localparam logic [ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/wb_slot.sv
// One-entry request slot. It has a valid/ready handshake, drops writes to the
// zero register, and empties when the arbiter grants it.
module wb_slot
   import wb_pkg::*;
#(
   parameter int DATA_W = wb_pkg::DATA_W,
   parameter int ADDR_W = wb_pkg::ADDR_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Valid,
   input  logic [ADDR_W-1:0] Reg,
   input  logic [DATA_W-1:0] Data,
   input  logic              Grant,
   output logic              Ready,
   output logic              Pending,
   output logic              Load,
   output logic [ADDR_W-1:0] SlotReg,
   output logic [DATA_W-1:0] SlotData
);

   logic              pending_q, pending_d;
   logic [ADDR_W-1:0] reg_q;
   logic [DATA_W-1:0] data_q;

   // Ready depends only on slot state and reset, never on Valid.
   assign Ready    = ~pending_q & ~Reset;
   assign Load     = Valid & Ready & (Reg != ADDR_W'(ZERO_REG));
   assign Pending  = pending_q;
   assign SlotReg  = reg_q;
   assign SlotData = data_q;

   always_comb begin
      pending_d = pending_q;
      if (Grant) pending_d = 1'b0;
      if (Load)  pending_d = 1'b1;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) pending_q <= 1'b0;
      else       pending_q <= pending_d;
   end

   always_ff @(posedge Clk) begin
      if (Load) begin
         reg_q  <= Reg;
         data_q <= Data;
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: two request slots (ALU, memory) drained oldest-first onto
// the single regfile write port, with read bypass for decode.
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_W = wb_pkg::DATA_W,
   parameter int ADDR_W = wb_pkg::ADDR_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              AluValid,
   output logic              AluReady,
   input  logic [ADDR_W-1:0] AluReg,
   input  logic [DATA_W-1:0] AluData,
   input  logic              MemValid,
   output logic              MemReady,
   input  logic [ADDR_W-1:0] MemReg,
   input  logic [DATA_W-1:0] MemData,
   output logic [ADDR_W-1:0] WriteRegister,
   output logic [DATA_W-1:0] WriteData,
   output logic              RegWrite,
   input  logic [ADDR_W-1:0] ReadRegister1,
   input  logic [ADDR_W-1:0] ReadRegister2,
   input  logic [DATA_W-1:0] ReadData1,
   input  logic [DATA_W-1:0] ReadData2,
   output logic [DATA_W-1:0] FwdData1,
   output logic [DATA_W-1:0] FwdData2,
   output logic              Busy
);

   logic              alu_pend, mem_pend, alu_load, mem_load, alu_grant, mem_grant;
   logic [ADDR_W-1:0] alu_reg, mem_reg;
   logic [DATA_W-1:0] alu_data, mem_data;

   logic              mem_older_q, mem_older_d;
   logic              reg_write_q, reg_write_d;
   logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   src_e              grant_src;

   logic              young_pend, old_pend;
   logic [ADDR_W-1:0] young_reg, old_reg;
   logic [DATA_W-1:0] young_data, old_data;

   wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
      .Clk(Clk), .Reset(Reset), .Valid(AluValid), .Reg(AluReg), .Data(AluData),
      .Grant(alu_grant), .Ready(AluReady), .Pending(alu_pend), .Load(alu_load),
      .SlotReg(alu_reg), .SlotData(alu_data)
   );

   wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
      .Clk(Clk), .Reset(Reset), .Valid(MemValid), .Reg(MemReg), .Data(MemData),
      .Grant(mem_grant), .Ready(MemReady), .Pending(mem_pend), .Load(mem_load),
      .SlotReg(mem_reg), .SlotData(mem_data)
   );

   always_comb begin
      grant_src = SRC_ALU;
      if (mem_pend & (~alu_pend | mem_older_q)) grant_src = SRC_MEM;
   end

   assign alu_grant = alu_pend & (grant_src == SRC_ALU);
   assign mem_grant = mem_pend & (grant_src == SRC_MEM);

   // A newly loaded slot is younger than a slot that survives this edge; a
   // same-edge double load counts Mem as older so Alu lands last.
   always_comb begin
      mem_older_d = mem_older_q;
      if (alu_load & mem_load) mem_older_d = 1'b1;
      else if (alu_load)       mem_older_d = mem_pend & ~mem_grant;
      else if (mem_load)       mem_older_d = ~(alu_pend & ~alu_grant);
   end

   always_comb begin
      reg_write_d = alu_pend | mem_pend;
      wr_reg_d    = wr_reg_q;
      wr_data_d   = wr_data_q;
      if (mem_grant) begin
         wr_reg_d  = mem_reg;
         wr_data_d = mem_data;
      end else if (alu_grant) begin
         wr_reg_d  = alu_reg;
         wr_data_d = alu_data;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         mem_older_q <= 1'b0;
         reg_write_q <= 1'b0;
         wr_reg_q    <= '0;
         wr_data_q   <= '0;
      end else begin
         mem_older_q <= mem_older_d;
         reg_write_q <= reg_write_d;
         wr_reg_q    <= wr_reg_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign WriteRegister = wr_reg_q;
   assign WriteData     = wr_data_q;
   assign RegWrite      = reg_write_q;
   assign Busy          = alu_pend | mem_pend | reg_write_q;

   always_comb begin
      if (mem_older_q) begin
         young_pend = alu_pend; young_reg = alu_reg; young_data = alu_data;
         old_pend   = mem_pend; old_reg   = mem_reg; old_data   = mem_data;
      end else begin
         young_pend = mem_pend; young_reg = mem_reg; young_data = mem_data;
         old_pend   = alu_pend; old_reg   = alu_reg; old_data   = alu_data;
      end
   end

   // Newest pending value wins, then the one about to commit, then the regfile.
   function automatic logic [DATA_W-1:0] fwd_sel(
      input logic [ADDR_W-1:0] rr,
      input logic [DATA_W-1:0] rd
   );
      logic [DATA_W-1:0] res;
      res = rd;
      if (rr != ADDR_W'(ZERO_REG)) begin
         if (young_pend && young_reg == rr)          res = young_data;
         else if (old_pend && old_reg == rr)         res = old_data;
         else if (reg_write_q && wr_reg_q == rr)     res = wr_data_q;
      end
      return res;
   endfunction

   always_comb begin
      FwdData1 = fwd_sel(ReadRegister1, ReadData1);
      FwdData2 = fwd_sel(ReadRegister2, ReadData2);
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a behavioural 32x32 regfile behind it.
module tb_writeback_arbiter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        AluValid, MemValid;
   logic        AluReady, MemReady;
   logic [4:0]  AluReg, MemReg;
   logic [31:0] AluData, MemData;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData;
   logic        RegWrite;
   logic [4:0]  ReadRegister1, ReadRegister2;
   logic [31:0] ReadData1, ReadData2;
   logic [31:0] FwdData1, FwdData2;
   logic        Busy;

   int checks   = 0;
   int failures = 0;
   int accepts  = 0;

   logic [31:0] rf [32];

   always #5 Clk = ~Clk;

   always @(posedge Clk) if (RegWrite) rf[WriteRegister] <= WriteData;
   assign ReadData1 = rf[ReadRegister1];
   assign ReadData2 = rf[ReadRegister2];

   writeback_arbiter dut (
      .Clk(Clk), .Reset(Reset),
      .AluValid(AluValid), .AluReady(AluReady), .AluReg(AluReg), .AluData(AluData),
      .MemValid(MemValid), .MemReady(MemReady), .MemReg(MemReg), .MemData(MemData),
      .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(ReadData1), .ReadData2(ReadData2),
      .FwdData1(FwdData1), .FwdData2(FwdData2), .Busy(Busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      Reset = 1'b1;
      AluValid = 0; MemValid = 0;
      AluReg = 0; MemReg = 0; AluData = 0; MemData = 0;
      ReadRegister1 = 0; ReadRegister2 = 0;
      step(); step();
      chk("rst_alu_ready", {31'd0, AluReady}, 32'd0);
      chk("rst_mem_ready", {31'd0, MemReady}, 32'd0);
      chk("rst_regwrite",  {31'd0, RegWrite}, 32'd0);
      chk("rst_wreg",      {27'd0, WriteRegister}, 32'd0);
      chk("rst_wdata",     WriteData, 32'd0);
      chk("rst_busy",      {31'd0, Busy}, 32'd0);
      Reset = 1'b0;
      #1;
      chk("rel_alu_ready", {31'd0, AluReady}, 32'd1);
      chk("rel_mem_ready", {31'd0, MemReady}, 32'd1);

      // Single ALU write
      AluValid = 1; AluReg = 3; AluData = 42; ReadRegister1 = 3;
      step();
      AluValid = 0;
      #1;
      chk("t1_pend_fwd",  FwdData1, 32'd42);
      chk("t1_pend_rw",   {31'd0, RegWrite}, 32'd0);
      chk("t1_busy",      {31'd0, Busy}, 32'd1);
      step();
      chk("t1_rw",        {31'd0, RegWrite}, 32'd1);
      chk("t1_wreg",      {27'd0, WriteRegister}, 32'd3);
      chk("t1_wdata",     WriteData, 32'd42);
      chk("t1_out_fwd",   FwdData1, 32'd42);
      step();
      chk("t1_rw_off",    {31'd0, RegWrite}, 32'd0);
      chk("t1_rf_fwd",    FwdData1, 32'd42);

      // Simultaneous writes to the same register
      MemValid = 1; MemReg = 5; MemData = 7;
      AluValid = 1; AluReg = 5; AluData = 9; ReadRegister1 = 5;
      step();
      MemValid = 0; AluValid = 0;
      #1;
      chk("t2_alu_ready", {31'd0, AluReady}, 32'd0);
      chk("t2_fwd_a",     FwdData1, 32'd9);
      step();
      chk("t2_rw1",       {31'd0, RegWrite}, 32'd1);
      chk("t2_wdata1",    WriteData, 32'd7);
      chk("t2_wreg1",     {27'd0, WriteRegister}, 32'd5);
      chk("t2_fwd_b",     FwdData1, 32'd9);
      step();
      chk("t2_rw2",       {31'd0, RegWrite}, 32'd1);
      chk("t2_wdata2",    WriteData, 32'd9);
      chk("t2_fwd_c",     FwdData1, 32'd9);
      step();
      chk("t2_rw_off",    {31'd0, RegWrite}, 32'd0);
      chk("t2_rf_fwd",    FwdData1, 32'd9);

      // Zero-register write is dropped
      AluValid = 1; AluReg = 0; AluData = 123; ReadRegister1 = 0;
      #1;
      chk("t3_ready",     {31'd0, AluReady}, 32'd1);
      step();
      AluValid = 0;
      #1;
      chk("t3_busy",      {31'd0, Busy}, 32'd0);
      chk("t3_ready_aft", {31'd0, AluReady}, 32'd1);
      chk("t3_fwd",       FwdData1, 32'd0);
      step();
      chk("t3_rw",        {31'd0, RegWrite}, 32'd0);

      // Backpressure: Valid held for four cycles
      AluReg = 6; ReadRegister1 = 6;
      for (int c = 0; c < 4; c++) begin
         AluValid = 1; AluData = 100 + c;
         #1;
         chk($sformatf("t4_ready_c%0d", c), {31'd0, AluReady}, (c % 2 == 0) ? 32'd1 : 32'd0);
         if (AluReady && AluValid) accepts++;
         step();
         chk($sformatf("t4_rw_c%0d", c), {31'd0, RegWrite}, (c % 2 == 1) ? 32'd1 : 32'd0);
         if (c == 1) chk("t4_wdata_a", WriteData, 32'd100);
         if (c == 3) chk("t4_wdata_b", WriteData, 32'd102);
      end
      AluValid = 0;
      chk("t4_accepts", accepts, 32'd2);
      step();
      chk("t4_rw_off",    {31'd0, RegWrite}, 32'd0);
      chk("t4_rf_fwd",    FwdData1, 32'd102);

      // Age ordering: Alu first, Mem one cycle later
      AluValid = 1; AluReg = 4; AluData = 1; ReadRegister2 = 4;
      step();
      AluValid = 0;
      MemValid = 1; MemReg = 4; MemData = 2;
      #1;
      chk("t5_mem_ready", {31'd0, MemReady}, 32'd1);
      step();
      MemValid = 0;
      #1;
      chk("t5_rw1",       {31'd0, RegWrite}, 32'd1);
      chk("t5_wdata1",    WriteData, 32'd1);
      chk("t5_fwd_a",     FwdData2, 32'd2);
      step();
      chk("t5_rw2",       {31'd0, RegWrite}, 32'd1);
      chk("t5_wdata2",    WriteData, 32'd2);
      chk("t5_fwd_b",     FwdData2, 32'd2);
      step();
      chk("t5_rw_off",    {31'd0, RegWrite}, 32'd0);
      chk("t5_rf_fwd",    FwdData2, 32'd2);

      // Reset with both slots pending
      AluValid = 1; AluReg = 7; AluData = 11;
      MemValid = 1; MemReg = 8; MemData = 22;
      ReadRegister1 = 7; ReadRegister2 = 8;
      step();
      AluValid = 0; MemValid = 0;
      #1;
      chk("t6_busy_pre",  {31'd0, Busy}, 32'd1);
      Reset = 1'b1;
      #1;
      chk("t6_rw",        {31'd0, RegWrite}, 32'd0);
      chk("t6_busy",      {31'd0, Busy}, 32'd0);
      chk("t6_alu_rdy",   {31'd0, AluReady}, 32'd0);
      chk("t6_mem_rdy",   {31'd0, MemReady}, 32'd0);
      step();
      chk("t6_rw_rst",    {31'd0, RegWrite}, 32'd0);
      Reset = 1'b0;
      #1;
      chk("t6_alu_rdy2",  {31'd0, AluReady}, 32'd1);
      chk("t6_mem_rdy2",  {31'd0, MemReady}, 32'd1);
      step();
      chk("t6_rw_a",      {31'd0, RegWrite}, 32'd0);
      step();
      chk("t6_rw_b",      {31'd0, RegWrite}, 32'd0);
      chk("t6_fwd1",      FwdData1, 32'd0);
      chk("t6_fwd2",      FwdData2, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
